// File: rtl/cache_control_nway_pkg.sv
// Shared types for the N-way cache controller: FSM state encoding,
// PLRU tree width helper and pmem address mux select values.
package cache_types;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    FILL
  } cache_state_t;

  // pmem_addr_sel encodings
  localparam logic PMEM_ADDR_CPU    = 1'b0;
  localparam logic PMEM_ADDR_VICTIM = 1'b1;

  // A binary PLRU tree over 'ways' leaves has ways-1 internal nodes.
  function automatic int unsigned PLRU_W(input int unsigned ways);
    return ways - 1;
  endfunction

endpackage

// File: rtl/cache_control_nway_plru_tree.sv
// Combinational tree pseudo-LRU for a power-of-two way count.
// Nodes are heap-ordered (root = bit 0, children of n are 2n+1 / 2n+2).
// A node bit of 0 points the victim toward the lower-index half, 1 toward
// the upper half. Touching a way flips every node on its path away from it.
module plru_tree
  import cache_types::*;
#(
  parameter int unsigned NUM_WAYS  = 4,
  parameter int unsigned WAY_IDX_W = $clog2(NUM_WAYS)
) (
  input  logic [PLRU_W(NUM_WAYS)-1:0] tree_in,
  input  logic [WAY_IDX_W-1:0]        touch_way,
  output logic [WAY_IDX_W-1:0]        victim_way,
  output logic [PLRU_W(NUM_WAYS)-1:0] tree_out
);

  // Walk from the root; at level lvl the node on the path is selected by
  // the victim bits already decided above it (prefix p).
  always_comb begin
    victim_way = '0;
    for (int unsigned lvl = 0; lvl < WAY_IDX_W; lvl++) begin
      for (int unsigned p = 0; p < (32'd1 << lvl); p++) begin
        if ((victim_way >> (WAY_IDX_W - lvl)) == WAY_IDX_W'(p))
          victim_way[WAY_IDX_W-1-lvl] = tree_in[(32'd1 << lvl) - 1 + p];
      end
    end
  end

  // Point every node on the touched way's path toward the opposite half.
  always_comb begin
    tree_out = tree_in;
    for (int unsigned lvl = 0; lvl < WAY_IDX_W; lvl++) begin
      for (int unsigned p = 0; p < (32'd1 << lvl); p++) begin
        if ((touch_way >> (WAY_IDX_W - lvl)) == WAY_IDX_W'(p))
          tree_out[(32'd1 << lvl) - 1 + p] = ~touch_way[WAY_IDX_W-1-lvl];
      end
    end
  end

endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative, write-back, write-allocate
// cache. Optional hit/miss counters are enabled by CACHE_PERF_CNT_EN.
module cache_control_nway
  import cache_types::*;
#(
  parameter int unsigned NUM_WAYS  = 4,
  parameter int unsigned WAY_IDX_W = $clog2(NUM_WAYS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [3:0]                  mem_byte_enable,
  output logic                        mem_resp,
  input  logic                        pmem_resp,
  output logic                        pmem_read,
  output logic                        pmem_write,
  input  logic [NUM_WAYS-1:0]         hit,
  input  logic [NUM_WAYS-1:0]         valid_out,
  input  logic [NUM_WAYS-1:0]         dirty_out,
  input  logic [PLRU_W(NUM_WAYS)-1:0] plru_in,
  output logic [PLRU_W(NUM_WAYS)-1:0] plru_out,
  output logic                        load_plru,
  output logic [NUM_WAYS-1:0]         load_data,
  output logic [NUM_WAYS-1:0]         load_tag,
  output logic [NUM_WAYS-1:0]         load_valid,
  output logic [NUM_WAYS-1:0]         load_dirty,
  output logic                        valid_in,
  output logic                        dirty_in,
  output logic [WAY_IDX_W-1:0]        way_sel,
  output logic                        data_sel,
  output logic                        pmem_addr_sel,
  output logic                        load_pmem_wdata
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
`endif
);

  cache_state_t                state_q, state_d;
  logic [WAY_IDX_W-1:0]        victim_q, victim;
  logic [WAY_IDX_W-1:0]        hit_way, invalid_way, plru_victim;
  logic [PLRU_W(NUM_WAYS)-1:0] plru_touched;
  logic [NUM_WAYS-1:0]         hit_oh, victim_oh;
  logic                        request, any_hit, any_invalid, miss_detect;

  // Byte enables are consumed by the datapath merge logic, not here.
  logic unused_byte_enable;
  assign unused_byte_enable = ^mem_byte_enable;

  assign request = mem_read | mem_write;

  // Priority-encode the hit way and the lowest invalid way.
  always_comb begin
    any_hit     = 1'b0;
    hit_way     = '0;
    any_invalid = 1'b0;
    invalid_way = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (hit[i] && !any_hit) begin
        any_hit = 1'b1;
        hit_way = WAY_IDX_W'(i);
      end
      if (!valid_out[i] && !any_invalid) begin
        any_invalid = 1'b1;
        invalid_way = WAY_IDX_W'(i);
      end
    end
  end

  plru_tree #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_IDX_W(WAY_IDX_W)
  ) u_plru (
    .tree_in   (plru_in),
    .touch_way (hit_way),
    .victim_way(plru_victim),
    .tree_out  (plru_touched)
  );

  assign victim      = any_invalid ? invalid_way : plru_victim;
  assign miss_detect = (state_q == IDLE) && request && !any_hit;
  assign hit_oh      = NUM_WAYS'(1) << hit_way;
  assign victim_oh   = NUM_WAYS'(1) << victim_q;

  // State register and victim latch; the victim is captured once per miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_detect)
        victim_q <= victim;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d         = state_q;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    plru_out        = '0;
    load_plru       = 1'b0;
    load_data       = '0;
    load_tag        = '0;
    load_valid      = '0;
    load_dirty      = '0;
    valid_in        = 1'b0;
    dirty_in        = 1'b0;
    way_sel         = '0;
    data_sel        = 1'b0;
    pmem_addr_sel   = PMEM_ADDR_CPU;
    load_pmem_wdata = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (request && any_hit) begin
          mem_resp  = 1'b1;
          way_sel   = hit_way;
          load_plru = 1'b1;
          plru_out  = plru_touched;
          if (mem_write) begin
            data_sel   = 1'b1;
            load_data  = hit_oh;
            dirty_in   = 1'b1;
            load_dirty = hit_oh;
          end
        end else if (request) begin
          state_d = (valid_out[victim] && dirty_out[victim]) ? WRITE_BACK : FILL;
        end
      end
      WRITE_BACK: begin
        pmem_write      = 1'b1;
        pmem_addr_sel   = PMEM_ADDR_VICTIM;
        way_sel         = victim_q;
        load_pmem_wdata = 1'b1;
        if (pmem_resp) begin
          load_dirty = victim_oh;
          state_d    = FILL;
        end
      end
      FILL: begin
        pmem_read  = 1'b1;
        way_sel    = victim_q;
        valid_in   = 1'b1;
        load_data  = victim_oh;
        load_tag   = victim_oh;
        load_valid = victim_oh;
        load_dirty = victim_oh;
        if (pmem_resp)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic post_fill_q;

  // Count CPU hits and miss detections; the hit that completes a miss is
  // not a CPU hit, so it is masked by post_fill_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count   <= '0;
      miss_count  <= '0;
      post_fill_q <= 1'b0;
    end else begin
      post_fill_q <= (state_q == FILL) && pmem_resp;
      if ((state_q == IDLE) && request && any_hit && !post_fill_q)
        hit_count <= hit_count + 32'd1;
      if (miss_detect)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

  hit_onehot_a : assert property (@(posedge clk) disable iff (rst)
    ((state_q == IDLE) && request) |-> $onehot0(hit))
    else $error("cache_control_nway: multiple hit bits set in one set");

endmodule

// File: tb/tb_cache_control_nway.sv
// Self-checking bench for cache_control_nway (NUM_WAYS=4), directed steps
// followed by randomized transactions against a behavioural model.
module tb_cache_control_nway;
  import cache_types::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write, mem_resp;
  logic [3:0]   mem_byte_enable;
  logic         pmem_resp, pmem_read, pmem_write;
  logic [N-1:0] hit, valid_out, dirty_out;
  logic [N-2:0] plru_in, plru_out;
  logic         load_plru;
  logic [N-1:0] load_data, load_tag, load_valid, load_dirty;
  logic         valid_in, dirty_in;
  logic [W-1:0] way_sel;
  logic         data_sel, pmem_addr_sel, load_pmem_wdata;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]  hit_count, miss_count;
`endif

  cache_control_nway #(.NUM_WAYS(N)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp),
    .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .hit(hit), .valid_out(valid_out), .dirty_out(dirty_out),
    .plru_in(plru_in), .plru_out(plru_out), .load_plru(load_plru),
    .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
    .load_dirty(load_dirty), .valid_in(valid_in), .dirty_in(dirty_in),
    .way_sel(way_sel), .data_sel(data_sel), .pmem_addr_sel(pmem_addr_sel),
    .load_pmem_wdata(load_pmem_wdata)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [N-2:0] plru_out;
    logic         load_plru;
    logic [N-1:0] load_data;
    logic [N-1:0] load_tag;
    logic [N-1:0] load_valid;
    logic [N-1:0] load_dirty;
    logic         valid_in;
    logic         dirty_in;
    logic [W-1:0] way_sel;
    logic         data_sel;
    logic         pmem_addr_sel;
    logic         load_pmem_wdata;
  } outs_t;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  function automatic outs_t observe();
    outs_t o;
    o.mem_resp = mem_resp;     o.pmem_read = pmem_read;
    o.pmem_write = pmem_write; o.plru_out = plru_out;
    o.load_plru = load_plru;   o.load_data = load_data;
    o.load_tag = load_tag;     o.load_valid = load_valid;
    o.load_dirty = load_dirty; o.valid_in = valid_in;
    o.dirty_in = dirty_in;     o.way_sel = way_sel;
    o.data_sel = data_sel;     o.pmem_addr_sel = pmem_addr_sel;
    o.load_pmem_wdata = load_pmem_wdata;
    return o;
  endfunction

  task automatic check(input string tag, input outs_t exp);
    outs_t obs;
    obs = observe();
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: interval-halving walk of the PLRU tree.
  function automatic int ref_plru_victim(input logic [N-2:0] t);
    int n = 0, lo = 0, sz = N;
    while (sz > 1) begin
      if (t[n]) begin lo += sz / 2; n = 2 * n + 2; end
      else n = 2 * n + 1;
      sz /= 2;
    end
    return lo;
  endfunction

  function automatic logic [N-2:0] ref_touch(input logic [N-2:0] t, input int w);
    logic [N-2:0] r = t;
    int n = 0, lo = 0, sz = N, half;
    while (sz > 1) begin
      half = sz / 2;
      if (w >= lo + half) begin r[n] = 1'b0; lo += half; n = 2 * n + 2; end
      else begin r[n] = 1'b1; n = 2 * n + 1; end
      sz = half;
    end
    return r;
  endfunction

  function automatic int ref_victim(input logic [N-1:0] valid, input logic [N-2:0] t);
    for (int i = 0; i < N; i++) if (!valid[i]) return i;
    return ref_plru_victim(t);
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  function automatic outs_t hit_exp(input logic [N-2:0] t, input int w, input logic wr);
    outs_t e = '0;
    e.mem_resp  = 1'b1;
    e.way_sel   = W'(w);
    e.load_plru = 1'b1;
    e.plru_out  = ref_touch(t, w);
    if (wr) begin
      e.data_sel   = 1'b1;
      e.load_data  = onehot(w);
      e.dirty_in   = 1'b1;
      e.load_dirty = onehot(w);
    end
    return e;
  endfunction

  // One CPU access; hit_w < 0 means the access misses.
  task automatic run_txn(input logic wr, input logic [N-1:0] valid, input logic [N-1:0] dirty,
                         input logic [N-2:0] t, input int hit_w, input int wb_cyc, input int fill_cyc);
    outs_t e;
    int v;
    @(negedge clk);
    mem_read = !wr; mem_write = wr; valid_out = valid; dirty_out = dirty;
    plru_in = t; pmem_resp = 1'b0;
    hit = (hit_w >= 0) ? onehot(hit_w) : '0;
    mem_byte_enable = 4'($urandom);
    #1;
    if (hit_w >= 0) begin
      check("hit", hit_exp(t, hit_w, wr));
      exp_hits++;
    end else begin
      check("miss_detect", '0);
      exp_misses++;
      v = ref_victim(valid, t);
      if (valid[v] && dirty[v]) begin
        for (int k = 0; k < wb_cyc; k++) begin
          @(negedge clk);
          pmem_resp = (k == wb_cyc - 1);
          #1;
          e = '0;
          e.pmem_write = 1'b1; e.pmem_addr_sel = 1'b1;
          e.way_sel = W'(v); e.load_pmem_wdata = 1'b1;
          if (pmem_resp) e.load_dirty = onehot(v);
          check("write_back", e);
        end
      end
      for (int k = 0; k < fill_cyc; k++) begin
        @(negedge clk);
        pmem_resp = (k == fill_cyc - 1);
        #1;
        e = '0;
        e.pmem_read = 1'b1; e.way_sel = W'(v); e.valid_in = 1'b1;
        e.load_data = onehot(v); e.load_tag = onehot(v);
        e.load_valid = onehot(v); e.load_dirty = onehot(v);
        check("fill", e);
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      valid_out[v] = 1'b1;
      dirty_out[v] = 1'b0;
      hit = onehot(v);
      #1;
      check("post_fill_hit", hit_exp(t, v, wr));
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; hit = '0;
    #1;
    check("idle", '0);
  endtask

  initial begin
    logic [N-1:0] rv, rd;
    logic [N-2:0] rt;
    int           hw;
    outs_t        e;

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0;
    pmem_resp = 1'b0; hit = '0; valid_out = '0; dirty_out = '0; plru_in = '0;

    // Reset held two cycles with no request.
    @(negedge clk); #1; check("reset_c1", '0);
    @(negedge clk); #1; check("reset_c2", '0);
    n_cmp++;
    assert (dut.state_q === IDLE) else begin
      n_bad++;
      $error("FAIL reset_state: observed %0d expected %0d", dut.state_q, IDLE);
    end
    rst = 1'b0;
    #1; check("idle_after_reset", '0);

    // Read hit on way 2 with an all-zero tree.
    run_txn(1'b0, 4'b0100, 4'b0000, 3'b000, 2, 0, 0);
    // Write miss into invalid way 3, 5-cycle fill, then write hit.
    run_txn(1'b1, 4'b0111, 4'b0000, 3'b000, -1, 0, 5);
    // Read miss, all ways valid and dirty: PLRU victim with write-back.
    run_txn(1'b0, 4'b1111, 4'b1111, 3'b011, -1, 3, 2);

`ifdef CACHE_PERF_CNT_EN
    check32("hit_count_directed", hit_count, 32'(exp_hits));
    check32("miss_count_directed", miss_count, 32'(exp_misses));
`endif

    // Reset during write-back abandons the transfer.
    @(negedge clk);
    mem_read = 1'b1; valid_out = 4'b1111; dirty_out = 4'b1111; plru_in = 3'b000; hit = '0;
    #1; check("abort_miss", '0);
    @(negedge clk); #1;
    e = '0; e.pmem_write = 1'b1; e.pmem_addr_sel = 1'b1; e.load_pmem_wdata = 1'b1;
    check("abort_write_back", e);
    rst = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    #1; check("abort_after_rst", '0);
    rst = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
`ifdef CACHE_PERF_CNT_EN
    check32("hit_count_rst", hit_count, 32'd0);
    check32("miss_count_rst", miss_count, 32'd0);
`endif
    run_txn(1'b0, 4'b1111, 4'b1111, 3'b000, -1, 2, 3);

    // Randomized accesses.
    for (int it = 0; it < 40; it++) begin
      rv = N'($urandom);
      rd = N'($urandom);
      rt = (N-1)'($urandom);
      hw = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1;
      if (hw >= 0) rv[hw] = 1'b1;
      run_txn(1'($urandom_range(0, 1)), rv, rd, rt, hw,
              int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
    end

`ifdef CACHE_PERF_CNT_EN
    check32("hit_count_random", hit_count, 32'(exp_hits));
    check32("miss_count_random", miss_count, 32'(exp_misses));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check32("hit_count_final_rst", hit_count, 32'd0);
    check32("miss_count_final_rst", miss_count, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
